// File: rtl/vote_decision_unit_if.sv
// Handshake and data bundle between the vote decision unit, its requester and the
// dataset compare unit. The slave side is the decision unit itself.
interface vote_decision_unit_if #(
    parameter int MAX_DATASETS = 9
);
    logic                      start;
    logic [3:0]                used_datasets;
    logic [3:0]                quorum;
    logic                      cmp_done;
    logic [4*MAX_DATASETS-1:0] match_cnt;
    logic                      cmp_clear;
    logic                      cmp_en;
    logic                      busy;
    logic                      result_valid;
    logic                      pass;
    logic [3:0]                majority_idx;
    logic [MAX_DATASETS-1:0]   failure_mask;
    logic                      timeout;
    logic                      config_error;

    modport master (
        output start, used_datasets, quorum, cmp_done, match_cnt,
        input  cmp_clear, cmp_en, busy, result_valid, pass, majority_idx,
               failure_mask, timeout, config_error
    );

    modport slave (
        input  start, used_datasets, quorum, cmp_done, match_cnt,
        output cmp_clear, cmp_en, busy, result_valid, pass, majority_idx,
               failure_mask, timeout, config_error
    );
endinterface

// File: rtl/vote_decision_unit.sv
// Sequences the dataset compare unit and scans its per-dataset match counts
// against a quorum, publishing pass/fail, first majority index and dissent mask.
module vote_decision_unit #(
    parameter int MAX_DATASETS   = 9,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    vote_decision_unit_if.slave     bus
);
    localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0] MAX_N    = 5'(MAX_DATASETS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COMPARE = 3'd2,
        ST_SCAN    = 3'd3,
        ST_REPORT  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              n_q, n_d;
    logic [3:0]              quorum_q, quorum_d;
    logic [3:0]              scan_idx_q, scan_idx_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [MAX_DATASETS-1:0] work_mask_q, work_mask_d;
    logic                    found_q, found_d;
    logic [3:0]              work_idx_q, work_idx_d;
    logic                    pass_q, pass_d;
    logic [3:0]              majority_idx_q, majority_idx_d;
    logic [MAX_DATASETS-1:0] failure_mask_q, failure_mask_d;
    logic                    timeout_q, timeout_d;
    logic                    config_error_q, config_error_d;

    logic                    cfg_bad_s;
    logic [3:0]              cur_cnt_s;
    logic [4:0]              cur_sum_s;
    logic                    below_s;
    logic [MAX_DATASETS-1:0] n_mask_s;

    // Next-state, working-register and published-result logic.
    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        quorum_d       = quorum_q;
        scan_idx_d     = scan_idx_q;
        tmo_cnt_d      = tmo_cnt_q;
        work_mask_d    = work_mask_q;
        found_d        = found_q;
        work_idx_d     = work_idx_q;
        pass_d         = pass_q;
        majority_idx_d = majority_idx_q;
        failure_mask_d = failure_mask_q;
        timeout_d      = timeout_q;
        config_error_d = config_error_q;

        cfg_bad_s = (bus.used_datasets < 4'd2) || ({1'b0, bus.used_datasets} > MAX_N) ||
                    (bus.quorum == 4'd0) || (bus.quorum > bus.used_datasets);

        cur_cnt_s = 4'd0;
        for (int i = 0; i < MAX_DATASETS; i++) begin
            if (4'(i) == scan_idx_q) begin
                cur_cnt_s = bus.match_cnt[4*i +: 4];
            end else begin
                cur_cnt_s = cur_cnt_s;
            end
            n_mask_s[i] = (4'(i) < n_q);
        end
        // Widened so a count of 15 plus the dataset itself cannot wrap.
        cur_sum_s = {1'b0, cur_cnt_s} + 5'd1;
        below_s   = (cur_sum_s < {1'b0, quorum_q});

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    n_d            = bus.used_datasets;
                    quorum_d       = bus.quorum;
                    pass_d         = 1'b0;
                    majority_idx_d = 4'd0;
                    failure_mask_d = '0;
                    timeout_d      = 1'b0;
                    config_error_d = cfg_bad_s;
                    state_d        = cfg_bad_s ? ST_REPORT : ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                scan_idx_d  = 4'd0;
                tmo_cnt_d   = '0;
                work_mask_d = '0;
                found_d     = 1'b0;
                work_idx_d  = 4'd0;
                state_d     = ST_COMPARE;
            end
            ST_COMPARE: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (bus.cmp_done) begin
                    state_d = ST_SCAN;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d      = 1'b1;
                    pass_d         = 1'b0;
                    majority_idx_d = 4'd0;
                    failure_mask_d = n_mask_s;
                    state_d        = ST_REPORT;
                end else begin
                    state_d = ST_COMPARE;
                end
            end
            ST_SCAN: begin
                scan_idx_d = scan_idx_q + 4'd1;
                for (int i = 0; i < MAX_DATASETS; i++) begin
                    if ((4'(i) == scan_idx_q) && below_s) begin
                        work_mask_d[i] = 1'b1;
                    end else begin
                        work_mask_d[i] = work_mask_q[i];
                    end
                end
                if (!below_s && !found_q) begin
                    found_d    = 1'b1;
                    work_idx_d = scan_idx_q;
                end else begin
                    found_d = found_q;
                end
                if (scan_idx_q == (n_q - 4'd1)) begin
                    pass_d         = found_d;
                    majority_idx_d = work_idx_d;
                    failure_mask_d = work_mask_d;
                    state_d        = ST_REPORT;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            n_q            <= 4'd0;
            quorum_q       <= 4'd0;
            scan_idx_q     <= 4'd0;
            tmo_cnt_q      <= '0;
            work_mask_q    <= '0;
            found_q        <= 1'b0;
            work_idx_q     <= 4'd0;
            pass_q         <= 1'b0;
            majority_idx_q <= 4'd0;
            failure_mask_q <= '0;
            timeout_q      <= 1'b0;
            config_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            quorum_q       <= quorum_d;
            scan_idx_q     <= scan_idx_d;
            tmo_cnt_q      <= tmo_cnt_d;
            work_mask_q    <= work_mask_d;
            found_q        <= found_d;
            work_idx_q     <= work_idx_d;
            pass_q         <= pass_d;
            majority_idx_q <= majority_idx_d;
            failure_mask_q <= failure_mask_d;
            timeout_q      <= timeout_d;
            config_error_q <= config_error_d;
        end
    end

    // Control strobes decode straight from the registered state.
    assign bus.cmp_clear    = (state_q == ST_CLEAR);
    assign bus.cmp_en       = (state_q == ST_COMPARE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.result_valid = (state_q == ST_REPORT);
    assign bus.pass         = pass_q;
    assign bus.majority_idx = majority_idx_q;
    assign bus.failure_mask = failure_mask_q;
    assign bus.timeout      = timeout_q;
    assign bus.config_error = config_error_q;
endmodule

// File: tb/tb_vote_decision_unit.sv
// Self-checking bench for vote_decision_unit: a vector table replayed through a
// behavioural compare-unit driver, with expected results queued on each start.
module tb_vote_decision_unit;
    localparam int MAXD = 9;
    localparam int TMO  = 64;

    logic clk;
    logic reset;

    vote_decision_unit_if #(.MAX_DATASETS(MAXD)) bus ();

    vote_decision_unit #(.MAX_DATASETS(MAXD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  n;
        logic [3:0]  q;
        logic [35:0] mc;
        int          done_at;
        int          extra_start;
        logic        exp_pass;
        logic [3:0]  exp_idx;
        logic [8:0]  exp_mask;
        logic        exp_tmo;
        logic        exp_cfg;
        int          exp_cycle;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];
    int   checks;
    int   errors;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] n, input logic [3:0] q,
                                input logic [35:0] mc, input int done_at, input int extra,
                                input logic p, input logic [3:0] idx, input logic [8:0] mask,
                                input logic tmo, input logic cfg);
        vec_t v;
        v.name = name; v.n = n; v.q = q; v.mc = mc; v.done_at = done_at;
        v.extra_start = extra; v.exp_pass = p; v.exp_idx = idx; v.exp_mask = mask;
        v.exp_tmo = tmo; v.exp_cfg = cfg;
        if (cfg)
            v.exp_cycle = 1;
        else if (done_at != 0)
            v.exp_cycle = done_at + int'(n) + 1;
        else
            v.exp_cycle = 2 + TMO;
        return v;
    endfunction

    // Drive one vote, acting as the compare unit, and score the published result.
    task automatic run_vote(input vec_t v);
        vec_t e;
        int   cyc;
        int   rv_cyc;
        int   en_cnt;
        int   clr_cnt;
        bit   seen;
        bus.start         = 1'b1;
        bus.used_datasets = v.n;
        bus.quorum        = v.q;
        bus.match_cnt     = v.mc;
        bus.cmp_done      = 1'b0;
        exp_q.push_back(v);
        tick();
        cyc = 1; rv_cyc = 0; en_cnt = 0; clr_cnt = 0; seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            bus.start = (cyc == v.extra_start);
            if (bus.cmp_en) en_cnt++;
            if (bus.cmp_clear) clr_cnt++;
            if (v.done_at != 0 && cyc >= v.done_at) bus.cmp_done = 1'b1;
            if (bus.result_valid) begin
                seen   = 1'b1;
                rv_cyc = cyc;
                bus.start = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        e = exp_q.pop_front();
        chk({e.name, " result_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({e.name, " rv_cycle"}, 32'(rv_cyc), 32'(e.exp_cycle));
            chk({e.name, " pass"}, 32'(bus.pass), 32'(e.exp_pass));
            chk({e.name, " majority_idx"}, 32'(bus.majority_idx), 32'(e.exp_idx));
            chk({e.name, " failure_mask"}, 32'(bus.failure_mask), 32'(e.exp_mask));
            chk({e.name, " timeout"}, 32'(bus.timeout), 32'(e.exp_tmo));
            chk({e.name, " config_error"}, 32'(bus.config_error), 32'(e.exp_cfg));
            chk({e.name, " cmp_clear_cycles"}, 32'(clr_cnt), e.exp_cfg ? 32'd0 : 32'd1);
            if (e.exp_cfg)
                chk({e.name, " cmp_en_cycles"}, 32'(en_cnt), 32'd0);
            else if (e.exp_tmo)
                chk({e.name, " cmp_en_cycles"}, 32'(en_cnt), 32'(TMO));
            else
                chk({e.name, " cmp_en_cycles"}, 32'(en_cnt), 32'(e.done_at - 1));
            // The start issued during REPORT must not launch a vote.
            tick();
            bus.start = 1'b0;
            chk({e.name, " idle_after_report"}, {31'd0, bus.busy}, 32'd0);
            chk({e.name, " result_hold"}, {22'd0, bus.pass, bus.failure_mask},
                {22'd0, e.exp_pass, e.exp_mask});
        end else begin
            bus.start = 1'b0;
        end
        bus.cmp_done = 1'b0;
    endtask

    logic [19:0] all_out;
    assign all_out = {bus.busy, bus.result_valid, bus.pass, bus.majority_idx,
                      bus.failure_mask, bus.timeout, bus.config_error,
                      bus.cmp_clear, bus.cmp_en};

    initial begin
        int rv_cnt;
        checks = 0;
        errors = 0;
        vecs[0]  = mk("unanimous",    4'd3, 4'd2, 36'h000000222, 5,  0, 1'b1, 4'd0, 9'b000000000, 1'b0, 1'b0);
        vecs[1]  = mk("one_dissent",  4'd5, 4'd3, 36'h000033331, 4,  0, 1'b1, 4'd1, 9'b000000001, 1'b0, 1'b0);
        vecs[2]  = mk("no_quorum",    4'd4, 4'd3, 36'h000001111, 6,  0, 1'b0, 4'd0, 9'b000001111, 1'b0, 1'b0);
        vecs[3]  = mk("timeout",      4'd3, 4'd2, 36'h000000222, 0,  0, 1'b0, 4'd0, 9'b000000111, 1'b1, 1'b0);
        vecs[4]  = mk("cfg_n1",       4'd1, 4'd1, 36'h000000000, 5,  0, 1'b0, 4'd0, 9'b000000000, 1'b0, 1'b1);
        vecs[5]  = mk("cfg_q0",       4'd3, 4'd0, 36'h000000222, 5,  0, 1'b0, 4'd0, 9'b000000000, 1'b0, 1'b1);
        vecs[6]  = mk("cfg_q_gt_n",   4'd3, 4'd4, 36'h000000222, 5,  0, 1'b0, 4'd0, 9'b000000000, 1'b0, 1'b1);
        vecs[7]  = mk("cfg_n_gt_max", 4'd10, 4'd2, 36'h000000222, 5, 0, 1'b0, 4'd0, 9'b000000000, 1'b0, 1'b1);
        vecs[8]  = mk("full_nine",    4'd9, 4'd9, 36'h788878F77, 3,  0, 1'b1, 4'd2, 9'b100010011, 1'b0, 1'b0);
        vecs[9]  = mk("n2_ignore_hi", 4'd2, 4'd2, 36'hFFFFFFF01, 2,  0, 1'b1, 4'd0, 9'b000000010, 1'b0, 1'b0);
        vecs[10] = mk("done_at_last", 4'd3, 4'd1, 36'h000000000, 65, 0, 1'b1, 4'd0, 9'b000000000, 1'b0, 1'b0);
        vecs[11] = mk("busy_start",   4'd2, 4'd2, 36'h000000000, 6,  3, 1'b0, 4'd0, 9'b000000011, 1'b0, 1'b0);

        reset = 1'b1;
        bus.start = 1'b0;
        bus.used_datasets = 4'd0;
        bus.quorum = 4'd0;
        bus.cmp_done = 1'b0;
        bus.match_cnt = '0;
        tick(); tick(); tick();
        chk("reset_outputs", {12'd0, all_out}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_outputs", {12'd0, all_out}, 32'd0);

        for (int i = 0; i < 12; i++) run_vote(vecs[i]);

        // Reset during SCAN discards the vote.
        bus.start = 1'b1;
        bus.used_datasets = 4'd5;
        bus.quorum = 4'd3;
        bus.match_cnt = 36'h000033331;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.cmp_done = 1'b1;
        tick();
        tick();
        chk("scan_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        tick();
        chk("reset_mid_scan", {12'd0, all_out}, 32'd0);
        reset = 1'b0;
        bus.cmp_done = 1'b0;
        rv_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.result_valid || bus.busy) rv_cnt++;
        end
        chk("no_result_after_reset", 32'(rv_cnt), 32'd0);

        run_vote(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
